// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 packet router.
// Header layout, FSM states and the port one-hot helper live here.
package router_pkg;

   typedef enum logic [2:0] {
      DECODE_ADDRESS,
      WAIT_TILL_EMPTY,
      LOAD_FIRST_DATA,
      LOAD_DATA,
      FIFO_FULL_STATE,
      CHECK_PARITY,
      DROP_PACKET
   } state_t;

   localparam logic [1:0] ADDR_INVALID = 2'b11;

   localparam int HDR_ADDR_LSB = 0;
   localparam int HDR_ADDR_MSB = 1;
   localparam int HDR_LEN_LSB  = 2;
   localparam int HDR_LEN_MSB  = 7;

   function automatic logic [2:0] port_sel(input logic [1:0] a);
      return 3'b001 << a;
   endfunction

endpackage

// File: rtl/router_softrst_timer.sv
// Per-port watchdog: pulses soft_rst when a port holds data
// but its reader has not strobed read_enb for TIMEOUT cycles.
module router_softrst_timer #(
   parameter int TIMEOUT = 30
) (
   input  logic clk,
   input  logic rst,
   input  logic read_enb,
   input  logic fifo_empty,
   output logic soft_rst
);

   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt;
   logic          inc;
   logic          hit;

   assign inc      = !read_enb && !fifo_empty;
   assign hit      = inc && (cnt == CW'(TIMEOUT - 1));
   assign soft_rst = rst && hit;

   // idle counter: clears on read/empty or after firing
   always_ff @(posedge clk) begin
      if (!rst)
         cnt <= '0;
      else if (!inc || hit)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/router_ctrl.sv
// Input-side controller of the 1x3 router: decodes the header,
// sequences FIFO writes, checks parity and drives soft resets.
module router_ctrl
   import router_pkg::*;
#(
   parameter int TIMEOUT = 30,
   parameter int NPORTS  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pkt_valid,
   input  logic [7:0]        data_in,
   input  logic [NPORTS-1:0] fifo_full,
   input  logic [NPORTS-1:0] fifo_empty,
   input  logic [NPORTS-1:0] read_enb,
   output logic [NPORTS-1:0] wr_en,
   output logic [7:0]        fifo_din,
   output logic              lfd_state,
   output logic [NPORTS-1:0] soft_rst,
   output logic [NPORTS-1:0] valid_out,
   output logic              busy,
   output logic              err
);

   state_t     state;
   state_t     nxt;
   logic [1:0] addr;
   logic [1:0] addr_reg;
   logic [7:0] hdr_reg;
   logic [7:0] parity;
   logic [7:0] rx_parity;
   logic       hdr_ld;
   logic       wait_ld;
   logic       par_acc;
   logic       par_ld;
   logic       chk;

   assign addr      = data_in[HDR_ADDR_MSB:HDR_ADDR_LSB];
   assign valid_out = ~fifo_empty;

   // state register
   always_ff @(posedge clk) begin
      if (!rst)
         state <= DECODE_ADDRESS;
      else
         state <= nxt;
   end

   // next state, write strobes and datapath load controls
   always_comb begin
      nxt       = state;
      wr_en     = '0;
      fifo_din  = '0;
      lfd_state = 1'b0;
      busy      = 1'b0;
      hdr_ld    = 1'b0;
      wait_ld   = 1'b0;
      par_acc   = 1'b0;
      par_ld    = 1'b0;
      chk       = 1'b0;
      if (rst) begin
         unique case (state)
            DECODE_ADDRESS: begin
               if (pkt_valid) begin
                  if (addr == ADDR_INVALID) begin
                     nxt = DROP_PACKET;
                  end else if (fifo_empty[addr]) begin
                     hdr_ld    = 1'b1;
                     lfd_state = 1'b1;
                     nxt       = LOAD_FIRST_DATA;
                  end else begin
                     wait_ld = 1'b1;
                     nxt     = WAIT_TILL_EMPTY;
                  end
               end
            end
            WAIT_TILL_EMPTY: begin
               busy = 1'b1;
               if (fifo_empty[addr_reg])
                  nxt = DECODE_ADDRESS;
            end
            LOAD_FIRST_DATA: begin
               busy     = 1'b1;
               wr_en    = port_sel(addr_reg);
               fifo_din = hdr_reg;
               nxt      = LOAD_DATA;
            end
            LOAD_DATA: begin
               busy = fifo_full[addr_reg];
               if (fifo_full[addr_reg]) begin
                  nxt = FIFO_FULL_STATE;
               end else begin
                  wr_en    = port_sel(addr_reg);
                  fifo_din = data_in;
                  if (pkt_valid) begin
                     par_acc = 1'b1;
                  end else begin
                     par_ld = 1'b1;
                     nxt    = CHECK_PARITY;
                  end
               end
            end
            FIFO_FULL_STATE: begin
               busy = 1'b1;
               if (!fifo_full[addr_reg])
                  nxt = LOAD_DATA;
            end
            CHECK_PARITY: begin
               busy = 1'b1;
               chk  = 1'b1;
               nxt  = DECODE_ADDRESS;
            end
            DROP_PACKET: begin
               if (!pkt_valid)
                  nxt = DECODE_ADDRESS;
            end
            default: nxt = DECODE_ADDRESS;
         endcase
      end
   end

   // header, destination, parity and error registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_reg  <= '0;
         hdr_reg   <= '0;
         parity    <= '0;
         rx_parity <= '0;
         err       <= 1'b0;
      end else begin
         if (hdr_ld) begin
            addr_reg <= addr;
            hdr_reg  <= data_in;
            parity   <= data_in;
            err      <= 1'b0;
         end
         if (wait_ld)
            addr_reg <= addr;
         if (par_acc)
            parity <= parity ^ data_in;
         if (par_ld)
            rx_parity <= data_in;
         if (chk)
            err <= (parity != rx_parity);
      end
   end

   for (genvar i = 0; i < NPORTS; i++) begin : g_tmr
      router_softrst_timer #(
         .TIMEOUT(TIMEOUT)
      ) u_tmr (
         .clk       (clk),
         .rst       (rst),
         .read_enb  (read_enb[i]),
         .fifo_empty(fifo_empty[i]),
         .soft_rst  (soft_rst[i])
      );
   end

endmodule

// File: doc/router_ctrl.md
Name: router_ctrl

Overview:
- Input-side controller for the 1x3 packet router.
- Accepts byte-serial packets from the source, decodes the destination, and sequences writes into one of three downstream 16-deep router FIFOs. The FIFO entry bit 8 marks a header; FIFOs are parameterised by DEPTH.
- Generates the header-marker strobe and checks packet parity.
- Handles FIFO backpressure, drives per-port valid_out, and issues per-port soft resets when a reader abandons its port.

Parameters:
- TIMEOUT, 30, cycles of valid_out without read_enb before soft_rst pulses.
- NPORTS, 3, number of destination FIFOs; fixed at 3 because address 2'b11 is reserved as invalid.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- pkt_valid  in  1  high for header and payload bytes; low for the parity byte
- data_in  in  8  packet byte; header format is [7:2] payload length, [1:0] destination address
- fifo_full  in  3  per-FIFO full flag
- fifo_empty  in  3  per-FIFO empty flag
- read_enb  in  3  per-port read strobe from the output side
- wr_en  out  3  one-hot FIFO write enable
- fifo_din  out  8  byte written to the FIFO selected by wr_en
- lfd_state  out  1  header-marker strobe; high in the cycle before the header write
- soft_rst  out  3  per-FIFO one-cycle soft-reset pulse
- valid_out  out  3  equal to ~fifo_empty
- busy  out  1  source must hold data_in and pkt_valid while high
- err  out  1  parity error, sticky until the next accepted header

Behaviour:
- Protocol: the source presents one byte per cycle, in the order header, payload bytes, then the parity byte with pkt_valid=0.
- A byte is consumed in any cycle with busy=0. When busy=1 the source holds the byte.
- Parity is the XOR of the header and all payload bytes. The parity byte is also written to the FIFO.
- Reset (rst=0 at posedge): state=DECODE_ADDRESS. wr_en, lfd_state, soft_rst, busy, err, parity accumulator, header register and timers all clear to 0. fifo_din=0.
- DECODE_ADDRESS: busy=0. Event handling with pkt_valid=1:
  - addr=3 -> DROP_PACKET; header consumed.
  - addr<3 and fifo_empty[addr]=1 -> header latched, addr_reg<=addr, parity<=header, err<=0, lfd_state=1 (combinational), next state LOAD_FIRST_DATA.
  - addr<3 and fifo_empty[addr]=0 -> WAIT_TILL_EMPTY; header not consumed; addr_reg<=addr.
  - pkt_valid=0: stay.
- WAIT_TILL_EMPTY: busy=1. Leave for DECODE_ADDRESS when fifo_empty[addr_reg]=1; the held header is then re-decoded.
- LOAD_FIRST_DATA: busy=1, wr_en[addr_reg]=1, fifo_din=latched header -> LOAD_DATA. Exactly one cycle.
- LOAD_DATA:
  - busy=fifo_full[addr_reg] (combinational).
  - Full -> FIFO_FULL_STATE, no write.
  - Not full, pkt_valid=1: wr_en[addr_reg]=1, fifo_din=data_in, parity^=data_in; stay.
  - Not full, pkt_valid=0: parity byte. Write it, latch it as rx_parity -> CHECK_PARITY.
- FIFO_FULL_STATE: busy=1, no write. Return to LOAD_DATA when fifo_full[addr_reg]=0. The held byte is then processed normally, so there is no byte loss or duplication.
- CHECK_PARITY: busy=1, one cycle. err<=(parity!=rx_parity) -> DECODE_ADDRESS.
- DROP_PACKET: busy=0, nothing written. Consume bytes while pkt_valid=1. Consume the parity byte (pkt_valid=0) -> DECODE_ADDRESS.
- Latency: header write occurs 1 cycle after header acceptance; each payload byte is written in the same cycle it is accepted.
- wr_en is never asserted to a full FIFO, and at most one wr_en bit is high at a time.
- Payload length in the header is not checked here; the FIFO uses it for readout.
- Soft-reset timer, per port i:
  - Counter clears when read_enb[i]=1 or fifo_empty[i]=1; otherwise it increments by 1.
  - When the counter reaches TIMEOUT-1 while incrementing, soft_rst[i]=1 for exactly one cycle and the counter clears.
  - Counter width is clog2(TIMEOUT).
  - soft_rst on addr_reg mid-packet does not change FSM state.
- Reset asserted mid-packet: the FSM is abandoned immediately and returns to DECODE_ADDRESS with all outputs cleared.

Decomposition:
- Package router_pkg holds:
  - state enum: DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, CHECK_PARITY, DROP_PACKET;
  - ADDR_INVALID=2'b11;
  - header field slice constants.
- Sub-module router_softrst_timer (one port, parameter TIMEOUT), instantiated NPORTS times.

Test Plan:
1. Header 0x0D (len 3, port 1), payload 0x11 0x22 0x33, parity 0x0D.
   - Required: lfd_state=1 in the header cycle, then wr_en=3'b010 for 5 cycles (0x0D, 0x11, 0x22, 0x33, 0x0D).
   - Required: err=0, valid_out[1]=1.
2. Same packet with parity 0x0C -> 5 writes still occur; err=1 after CHECK_PARITY; err clears on the next accepted header.
3. Header 0x0B (addr 3), 2 payload bytes + parity -> wr_en stays 0 throughout; FSM returns to DECODE_ADDRESS.
4. fifo_full[1] forced high before the 2nd payload byte (0x22) of the scenario-1 packet.
   - Required: busy=1, no writes while full.
   - Required: on release, 0x22 is written exactly once and the packet completes.
5. fifo_empty[1]=0 when header 0x0D arrives -> busy=1, no writes; when fifo_empty[1] rises, the header is accepted one cycle later.
6. Port 0 non-empty with read_enb[0]=0 for 30 cycles -> soft_rst[0] pulses one cycle on the 30th. A read_enb[0] pulse at cycle 15 restarts the count.
